// File: rtl/program_loader.sv
// Writer side of the instruction memory: streams 2-bit words into addresses 0..DEPTH-1,
// holds the core, pulses pc_reset, then releases it. Optional: ILLEGAL_OP_CHECK_EN.
module program_loader #(
    parameter int INSTR_WIDTH = 2,
    parameter int ADDR_WIDTH  = 2,
    parameter int DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_data,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_data,
    output logic [1:0]             pc_reset,
    output logic                   cpu_hold,
    output logic                   load_done,
    output logic                   error
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PCRST,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
`ifdef ILLEGAL_OP_CHECK_EN
    localparam logic [INSTR_WIDTH-1:0] OP_ILL = '1;
    localparam logic [INSTR_WIDTH-1:0] OP_HLT = INSTR_WIDTH'(2);
`endif

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  count_q, count_d;
    logic                   in_ready_d;
    logic                   mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [INSTR_WIDTH-1:0] mem_data_d;
    logic [1:0]             pc_reset_d;
    logic                   cpu_hold_d;
    logic                   load_done_d;
    logic                   error_d;
    logic [INSTR_WIDTH-1:0] word;
    logic                   accept;

    assign accept = in_valid & in_ready;

    // Next state and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        in_ready_d  = in_ready;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_data_d  = mem_data;
        pc_reset_d  = 2'b00;
        cpu_hold_d  = cpu_hold;
        load_done_d = load_done;
        error_d     = error;
        word        = in_data;
`ifdef ILLEGAL_OP_CHECK_EN
        if (in_data == OP_ILL) begin
            word = OP_HLT;
        end
`endif
        unique case (state_q)
            IDLE: begin
                cpu_hold_d  = 1'b1;
                load_done_d = 1'b0;
                in_ready_d  = 1'b0;
                if (start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    error_d    = 1'b0;
                    in_ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = count_q;
                    mem_data_d = word;
`ifdef ILLEGAL_OP_CHECK_EN
                    if (in_data == OP_ILL) begin
                        error_d = 1'b1;
                    end
`endif
                    if (count_q == LAST) begin
                        state_d    = PCRST;
                        in_ready_d = 1'b0;
                        pc_reset_d = 2'b11;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            PCRST: begin
                // A flagged image leaves the core held.
                if (error) begin
                    state_d = IDLE;
                end else begin
                    state_d     = RUN;
                    cpu_hold_d  = 1'b0;
                    load_done_d = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    state_d     = LOAD;
                    count_d     = '0;
                    error_d     = 1'b0;
                    in_ready_d  = 1'b1;
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            pc_reset  <= 2'b00;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            in_ready  <= in_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_data  <= mem_data_d;
            pc_reset  <= pc_reset_d;
            cpu_hold  <= cpu_hold_d;
            load_done <= load_done_d;
            error     <= error_d;
        end
    end

endmodule
